// File: rtl/clap_sequence_decoder.sv
// Groups synchronized clap events into quiet-gap separated sequences and
// reports each finished sequence as a one-cycle command strobe carrying its count.
module clap_sequence_decoder #(
  parameter int unsigned GAP_MAX      = 50_000_000,
  parameter int unsigned MIN_GAP      = 10_000_000,
  parameter int unsigned MAX_CLAPS    = 3,
  parameter int unsigned TOGGLE_COUNT = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clap_pulse_i,
  output logic       cmd_valid_o,
  output logic [2:0] cmd_count_o,
  output logic       error_o,
  output logic       toggle_o,
  output logic       busy_o
);

  localparam int unsigned   GW        = $clog2(GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_MAX - 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(GAP_MAX);
  localparam logic [GW-1:0] GAP_MIN   = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);
  localparam logic [2:0]    COUNT_MAX = 3'(MAX_CLAPS);
  localparam logic [2:0]    COUNT_TOG = 3'(TOGGLE_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q;
  logic          s1_q, s2_q, s3_q;
  logic          evt_q;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [2:0]    count_q;
  logic          cmd_valid_q;
  logic [2:0]    cmd_count_q;
  logic          error_q;
  logic          toggle_q;
  logic          busy_q;

  always_comb begin
    gap_d = (gap_q == GAP_SAT) ? gap_q : gap_q + GAP_ONE;
  end

  // cmd_valid_o and error_o are single-cycle strobes without a ready:
  // the consumer must capture cmd_count_o in the cycle cmd_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      evt_q       <= 1'b0;
      state_q     <= IDLE;
      gap_q       <= '0;
      count_q     <= 3'd0;
      cmd_valid_q <= 1'b0;
      cmd_count_q <= 3'd0;
      error_q     <= 1'b0;
      toggle_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= clap_pulse_i;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      // Registered rising-edge event: one cycle per clap however long the pulse.
      evt_q       <= s2_q & ~s3_q;
      cmd_valid_q <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evt_q) begin
            count_q <= 3'd1;
            gap_q   <= '0;
            state_q <= COLLECT;
            busy_q  <= 1'b1;
          end
        end
        COLLECT: begin
          if (evt_q && gap_q >= GAP_MIN) begin
            gap_q <= '0;
            if (count_q < COUNT_MAX) begin
              count_q <= count_q + 3'd1;
            end else begin
              error_q <= 1'b1;
              state_q <= DISCARD;
            end
          end else if (!evt_q && gap_q == GAP_LAST) begin
            cmd_valid_q <= 1'b1;
            cmd_count_q <= count_q;
            if (count_q == COUNT_TOG) begin
              toggle_q <= ~toggle_q;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_d;
          end
        end
        DISCARD: begin
          // Overlong sequence: any clap extends it, and it ends without a command.
          if (evt_q) begin
            gap_q <= '0;
          end else if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_count_o = cmd_count_q;
  assign error_o     = error_q;
  assign toggle_o    = toggle_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_clap_sequence_decoder.sv
// Bench for clap_sequence_decoder: planned clap trains go through a sequence-level
// reference model that queues expected strobes; a negedge monitor pops and compares.
module tb_clap_sequence_decoder;

  localparam int GAP_MAX      = 100;
  localparam int MIN_GAP      = 20;
  localparam int MAX_CLAPS    = 3;
  localparam int TOGGLE_COUNT = 2;
  localparam int LAT          = 3;

  logic       clk;
  logic       rst;
  logic       clap;
  logic       cmd_valid;
  logic [2:0] cmd_count;
  logic       error;
  logic       toggle;
  logic       busy;

  clap_sequence_decoder #(
    .GAP_MAX(GAP_MAX),
    .MIN_GAP(MIN_GAP),
    .MAX_CLAPS(MAX_CLAPS),
    .TOGGLE_COUNT(TOGGLE_COUNT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .clap_pulse_i(clap),
    .cmd_valid_o(cmd_valid),
    .cmd_count_o(cmd_count),
    .error_o(error),
    .toggle_o(toggle),
    .busy_o(busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish before 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Packet: {is_cmd, cmd_count, toggle, cycle of the strobe}
  function automatic logic [31:0] pkt(input bit kind, input int cnt, input bit tog, input int c);
    return {kind, 3'(cnt), tog, 27'(c)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid || error) begin
      logic [31:0] act;
      logic [31:0] exp;
      act = pkt(cmd_valid, int'(cmd_count), toggle, cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_strobe: got %h expected none (cycle %0d)", act, cyc);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL strobe: got kind=%0d cnt=%0d tog=%0d cyc=%0d expected kind=%0d cnt=%0d tog=%0d cyc=%0d",
                   act[31], act[30:28], act[27], act[26:0], exp[31], exp[30:28], exp[27], exp[26:0]);
        end
      end
      n_checks++;
      if (cmd_valid && error) begin
        n_errors++;
        $display("FAIL exclusive: got cmd_valid=1 error=1 expected at most one (cycle %0d)", cyc);
      end
    end
  end

  // ---------------- reference model (sequence level) ----------------
  // A sequence is a run of accepted claps; it closes GAP_MAX edges after the
  // last accepted one unless another clap arrives by then. The gap counter the
  // design sees at edge t is t - last - 1.
  bit m_in_seq = 0;
  bit m_discard = 0;
  int m_count = 0;
  int m_last = 0;
  bit m_toggle = 0;
  int m_last_cmd = 0;

  function automatic void m_close_if_due(input int t);
    if (m_in_seq && t > m_last + GAP_MAX) begin
      if (!m_discard) begin
        m_last_cmd = m_count;
        if (m_count == TOGGLE_COUNT) m_toggle = ~m_toggle;
        exp_q.push_back(pkt(1'b1, m_last_cmd, m_toggle, m_last + GAP_MAX));
      end
      m_in_seq = 0;
      m_discard = 0;
    end
  endfunction

  function automatic void m_event(input int t);
    m_close_if_due(t);
    if (!m_in_seq) begin
      m_in_seq = 1;
      m_discard = 0;
      m_count = 1;
      m_last = t;
    end else if (m_discard) begin
      m_last = t;
    end else if (t - m_last - 1 >= MIN_GAP) begin
      if (m_count < MAX_CLAPS) begin
        m_count++;
        m_last = t;
      end else begin
        m_discard = 1;
        m_last = t;
        exp_q.push_back(pkt(1'b0, m_last_cmd, m_toggle, t));
      end
    end
  endfunction

  function automatic void m_reset(input int r);
    m_close_if_due(r);
    m_in_seq = 0;
    m_discard = 0;
    m_toggle = 0;
    m_last_cmd = 0;
  endfunction

  // ---------------- driver ----------------
  int p_n;
  int p_rise[8];
  int p_width[8];

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // p_rise is the first edge that samples the pulse high
  task automatic plan_model(input int reset_at);
    for (int i = 0; i < p_n; i++) m_event(p_rise[i] + LAT);
    if (reset_at >= 0) m_reset(reset_at);
    else m_close_if_due(32'h3fff_ffff);
  endtask

  task automatic drive_planned();
    for (int i = 0; i < p_n; i++) begin
      wait_cyc(p_rise[i] - 1);
      clap = 1'b1;
      wait_cyc(p_rise[i] - 1 + p_width[i]);
      clap = 1'b0;
    end
  endtask

  task automatic finish_test(input string name);
    wait_cyc(p_rise[p_n-1] + LAT + GAP_MAX + 4);
    chk({name, "_busy_idle"}, int'(busy), 0);
    chk({name, "_toggle"}, int'(toggle), int'(m_toggle));
    chk({name, "_count_hold"}, int'(cmd_count), m_last_cmd);
  endtask

  task automatic run_test(input string name, input int reset_at);
    plan_model(reset_at);
    drive_planned();
    finish_test(name);
  endtask

  task automatic set_train(input int n, input int base, input int spacing, input int width);
    p_n = n;
    for (int i = 0; i < n; i++) begin
      p_rise[i] = base + i * spacing;
      p_width[i] = width;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int sp_tab[4];
    sp_tab[0] = 20; sp_tab[1] = 21; sp_tab[2] = 100; sp_tab[3] = 101;
    rst = 1'b1;
    clap = 1'b0;
    @(negedge clk);
    wait_cyc(2);
    chk("reset_cmd_valid", int'(cmd_valid), 0);
    chk("reset_cmd_count", int'(cmd_count), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_toggle", int'(toggle), 0);
    chk("reset_busy", int'(busy), 0);
    wait_cyc(3);
    rst = 1'b0;

    // 1: single clap sampled at edge 10, accepted at 13, strobe at 113
    set_train(1, 10, 0, 32);
    plan_model(-1);
    drive_planned();
    wait_cyc(112);
    chk("t1_busy_before", int'(busy), 1);
    wait_cyc(113);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_count", int'(cmd_count), 1);
    finish_test("t1");

    // 2: double clap toggles, twice
    set_train(2, cyc + 10, 40, 32);
    run_test("t2a", -1);
    chk("t2a_toggle_on", int'(toggle), 1);
    set_train(2, cyc + 10, 40, 32);
    run_test("t2b", -1);
    chk("t2b_toggle_off", int'(toggle), 0);

    // 3: second edge inside debounce window is ignored
    set_train(2, cyc + 10, 10, 5);
    run_test("t3", -1);
    chk("t3_count", int'(cmd_count), 1);

    // 4: four claps overflow, then a fresh single clap
    set_train(4, cyc + 10, 30, 20);
    run_test("t4", -1);
    set_train(1, cyc + 10, 0, 32);
    run_test("t4b", -1);
    chk("t4b_count", int'(cmd_count), 1);

    // 5: reset drops a sequence in progress
    set_train(1, cyc + 10, 0, 32);
    base = p_rise[0] + LAT + 50;
    plan_model(base);
    drive_planned();
    wait_cyc(base - 1);
    rst = 1'b1;
    wait_cyc(base);
    rst = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_cmd_valid", int'(cmd_valid), 0);
    chk("t5_count", int'(cmd_count), 0);
    chk("t5_toggle", int'(toggle), 0);
    finish_test("t5");

    // 6: accept on the same edge as the timeout: the clap wins
    set_train(2, cyc + 10, GAP_MAX, 32);
    run_test("t6", -1);
    chk("t6_count", int'(cmd_count), 2);

    // random clap trains
    for (int k = 0; k < 25; k++) begin
      p_n = $urandom_range(1, 5);
      p_rise[0] = cyc + 10;
      for (int i = 1; i < p_n; i++) begin
        int sp;
        if ($urandom_range(0, 3) == 0) sp = sp_tab[$urandom_range(0, 3)];
        else sp = $urandom_range(8, 130);
        p_rise[i] = p_rise[i-1] + sp;
      end
      for (int i = 0; i < p_n; i++) begin
        int wmax;
        wmax = 32;
        if (i < p_n - 1 && p_rise[i+1] - p_rise[i] - 2 < wmax) wmax = p_rise[i+1] - p_rise[i] - 2;
        p_width[i] = $urandom_range(2, wmax);
      end
      run_test("rand", -1);
    end

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
